// File: rtl/vfpu_fma_issue_arb_pkg.sv
// Shared definitions for the vfpu FMA issue arbiter: FSM encoding, the canonical
// quiet NaN and the width of one in-flight tag entry.
package vfpu_fma_issue_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_UPDATE = 2'd2
  } arb_state_e;

  localparam logic [31:0] FP32_QNAN = 32'h7fc0_0000;

  // Tag entry layout: {valid, kill, id}
  function automatic int tag_w(input int idw);
    return idw + 2;
  endfunction

endpackage

// File: rtl/vfpu_rr_pick.sv
// Round-robin priority select: first valid lane at or above ptr_i, wrapping mod NREQ.
module vfpu_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] cand_s;

  // Scan offsets from the farthest down to zero so the nearest valid lane wins.
  always_comb begin
    cand_s = '0;
    idx_o  = ptr_i;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_s = ptr_i + IDW'(i);
      if (valid_i[cand_s]) begin
        idx_o = cand_s;
      end else begin
        idx_o = idx_o;
      end
    end
  end

  assign any_o   = |valid_i;
  assign grant_o = any_o ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_o) : {NREQ{1'b0}};

endmodule

// File: rtl/vfpu_fma_issue_arb.sv
// Issue scheduler for the shared FMA pipe: round-robin issue, tag tracking, result
// routing and drained nj_mode updates. Optional counters: VFPU_ARB_PERF_CNT_EN.
module vfpu_fma_issue_arb
  import vfpu_fma_issue_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int IDW  = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ-1:0]   req_inv_mask_i,
  input  logic [NREQ*32-1:0] req_opa_i,
  input  logic [NREQ*32-1:0] req_opb_i,
  input  logic [NREQ*32-1:0] req_opc_i,
  output logic              fma_valid_o,
  output logic [31:0]       fma_opa_o,
  output logic [31:0]       fma_opb_o,
  output logic [31:0]       fma_opc_o,
  output logic              fma_inv_mask_o,
  output logic              fma_nj_mode_o,
  input  logic              fma_res_valid_i,
  input  logic [31:0]       fma_res_i,
  input  logic              fma_res_spec_i,
  output logic [NREQ-1:0]   res_valid_o,
  output logic [31:0]       res_data_o,
  output logic              res_spec_o,
  input  logic              flush_i,
  input  logic              cfg_wr_i,
  input  logic              cfg_nj_mode_i,
  output logic              cfg_busy_o,
  output logic              cfg_done_o,
  output logic              err_o
`ifdef VFPU_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issue_o,
  output logic [31:0]       perf_spec_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int TW = tag_w(IDW);
  localparam int CW = $clog2(LAT + 2);

  arb_state_e        state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    issue_id_q;
  logic              fma_valid_q;
  logic [31:0]       fma_opa_q, fma_opb_q, fma_opc_q;
  logic              fma_inv_mask_q;
  logic              nj_mode_q, nj_lat_q, cfg_done_q, err_q;
  logic [NREQ-1:0]   res_valid_q;
  logic [31:0]       res_data_q;
  logic              res_spec_q;
  logic [CW-1:0]     inflight_q;
  logic [TW-1:0]     tag_q [LAT];
  logic [TW-1:0]     tag0_d;
  logic [NREQ-1:0]   res_oh_d;

  logic [NREQ-1:0]   pick_gnt_s;
  logic [IDW-1:0]    pick_idx_s;
  logic              pick_any_s;
  logic              accept_s, tail_v_s, tail_kill_s, deliver_s;
  logic [IDW-1:0]    tail_id_s;

  vfpu_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_gnt_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

  // A cfg_wr in RUN already blocks issue so the drain starts from a quiet pipe.
  assign accept_s    = rst_n_i & (state_q == ST_RUN) & ~flush_i & ~cfg_wr_i & pick_any_s;
  assign req_ready_o = accept_s ? pick_gnt_s : {NREQ{1'b0}};

  // A flush kills the tail being retired in the same cycle as well.
  assign tail_v_s    = tag_q[LAT-1][TW-1];
  assign tail_kill_s = tag_q[LAT-1][TW-2] | flush_i;
  assign tail_id_s   = tag_q[LAT-1][IDW-1:0];
  assign deliver_s   = tail_v_s & ~tail_kill_s & fma_res_valid_i;
  assign tag0_d      = {fma_valid_q, fma_valid_q & flush_i, issue_id_q};
  assign res_oh_d    = {{(NREQ-1){1'b0}}, 1'b1} << tail_id_s;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fma_valid_q    <= 1'b0;
      fma_opa_q      <= 32'h0000_0000;
      fma_opb_q      <= 32'h0000_0000;
      fma_opc_q      <= 32'h0000_0000;
      fma_inv_mask_q <= 1'b0;
      issue_id_q     <= '0;
      rr_ptr_q       <= '0;
    end else begin
      fma_valid_q <= accept_s;
      if (accept_s) begin
        fma_opa_q      <= req_opa_i[32*pick_idx_s +: 32];
        fma_opb_q      <= req_opb_i[32*pick_idx_s +: 32];
        fma_opc_q      <= req_opc_i[32*pick_idx_s +: 32];
        fma_inv_mask_q <= req_inv_mask_i[pick_idx_s];
        issue_id_q     <= pick_idx_s;
        rr_ptr_q       <= pick_idx_s + IDW'(1'b1);
      end
    end
  end

  // Tag pipe mirrors the FMA pipe; flush marks every live entry as killed.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      inflight_q <= '0;
    end else begin
      tag_q[0] <= tag0_d;
      for (int k = 1; k < LAT; k++) begin
        tag_q[k] <= {tag_q[k-1][TW-1], tag_q[k-1][TW-2] | (flush_i & tag_q[k-1][TW-1]),
                     tag_q[k-1][IDW-1:0]};
      end
      case ({fma_valid_q, tail_v_s})
        2'b10:   inflight_q <= inflight_q + CW'(1'b1);
        2'b01:   inflight_q <= inflight_q - CW'(1'b1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      res_valid_q <= '0;
      res_data_q  <= 32'h0000_0000;
      res_spec_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= deliver_s ? res_oh_d : {NREQ{1'b0}};
      res_spec_q  <= deliver_s & fma_res_spec_i;
      if (deliver_s) res_data_q <= fma_res_i;
      if (tail_v_s ^ fma_res_valid_i) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RUN;
      nj_lat_q   <= 1'b0;
      nj_mode_q  <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          cfg_done_q <= 1'b0;
          if (cfg_wr_i) begin
            nj_lat_q <= cfg_nj_mode_i;
            state_q  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((inflight_q == '0) && !fma_valid_q) begin
            nj_mode_q  <= nj_lat_q;
            cfg_done_q <= 1'b1;
            state_q    <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          cfg_done_q <= 1'b0;
          state_q    <= ST_RUN;
        end
        default: begin
          cfg_done_q <= 1'b0;
          state_q    <= ST_RUN;
        end
      endcase
    end
  end

`ifdef VFPU_ARB_PERF_CNT_EN
  logic [31:0] perf_issue_q, perf_spec_q, perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      perf_issue_q <= 32'd0;
      perf_spec_q  <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (fma_valid_q) perf_issue_q <= perf_issue_q + 32'd1;
      if (deliver_s && fma_res_spec_i) perf_spec_q <= perf_spec_q + 32'd1;
      if ((|req_valid_i) && !accept_s) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue_o = perf_issue_q;
  assign perf_spec_o  = perf_spec_q;
  assign perf_stall_o = perf_stall_q;
`endif

  assign fma_valid_o    = fma_valid_q;
  assign fma_opa_o      = fma_opa_q;
  assign fma_opb_o      = fma_opb_q;
  assign fma_opc_o      = fma_opc_q;
  assign fma_inv_mask_o = fma_inv_mask_q;
  assign fma_nj_mode_o  = nj_mode_q;
  assign res_valid_o    = res_valid_q;
  assign res_data_o     = res_data_q;
  assign res_spec_o     = res_spec_q;
  assign cfg_busy_o     = (state_q != ST_RUN);
  assign cfg_done_o     = cfg_done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_vfpu_fma_issue_arb.sv
// Scoreboard bench for vfpu_fma_issue_arb with a fixed-latency model FMA pipe.
module tb_vfpu_fma_issue_arb;

  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int IDW  = 2;
  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  logic              clk, rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, req_inv, res_valid;
  logic [NREQ*32-1:0] req_opa, req_opb, req_opc;
  logic              fma_valid, fma_inv, fma_nj;
  logic [31:0]       fma_opa, fma_opb, fma_opc, fma_res, res_data;
  logic              fma_res_valid, fma_res_spec, res_spec;
  logic              flush, cfg_wr, cfg_nj, cfg_busy, cfg_done, err;
  logic              inj, sb_drop;
  logic [31:0]       cyc;
  int                errors, checks;

  typedef struct packed {
    logic [3:0]  lane;
    logic [31:0] data;
    logic        spec;
    logic [31:0] due;
  } sb_t;
  sb_t         sb_q[$];
  sb_t         sb_e;
  logic [32:0] mon_m;

  logic        pv [LAT];
  logic [32:0] pd [LAT];

  vfpu_fma_issue_arb #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_inv_mask_i(req_inv),
    .req_opa_i(req_opa), .req_opb_i(req_opb), .req_opc_i(req_opc),
    .fma_valid_o(fma_valid), .fma_opa_o(fma_opa), .fma_opb_o(fma_opb), .fma_opc_o(fma_opc),
    .fma_inv_mask_o(fma_inv), .fma_nj_mode_o(fma_nj),
    .fma_res_valid_i(fma_res_valid), .fma_res_i(fma_res), .fma_res_spec_i(fma_res_spec),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_spec_o(res_spec),
    .flush_i(flush), .cfg_wr_i(cfg_wr), .cfg_nj_mode_i(cfg_nj),
    .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment model of the FMA: inf*0 produces the quiet NaN via the special path.
  function automatic logic [32:0] fma_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic inv);
    logic sp;
    sp = ((a[30:0] == 31'h7f80_0000) && (b[30:0] == 31'd0)) ||
         ((b[30:0] == 31'h7f80_0000) && (a[30:0] == 31'd0));
    return sp ? {1'b1, QNAN} : {1'b0, a ^ {b[15:0], b[31:16]} ^ c ^ {31'd0, inv}};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        pv[k] <= 1'b0;
        pd[k] <= 33'd0;
      end
    end else begin
      pv[0] <= fma_valid;
      pd[0] <= fma_model(fma_opa, fma_opb, fma_opc, fma_inv);
      for (int k = 1; k < LAT; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end
  end

  assign fma_res_valid = pv[LAT-1] | inj;
  assign fma_res       = pd[LAT-1][31:0];
  assign fma_res_spec  = pd[LAT-1][32];

  always @(posedge clk) cyc <= (rst_n === 1'b1) ? cyc + 32'd1 : 32'd0;

  // Scoreboard monitor: push on accept, pop and compare on every delivered result.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (res_valid !== 4'b0000) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got res_valid=%b data=%h, expected no result",
                     res_valid, res_data);
          end else begin
            sb_e = sb_q.pop_front();
            if (res_valid !== sb_e.lane || res_data !== sb_e.data ||
                res_spec !== sb_e.spec || cyc !== sb_e.due) begin
              errors++;
              $display("FAIL sb_result: got lane=%b data=%h spec=%b cyc=%0d, expected lane=%b data=%h spec=%b cyc=%0d",
                       res_valid, res_data, res_spec, cyc, sb_e.lane, sb_e.data, sb_e.spec, sb_e.due);
            end
          end
        end
        if ((req_ready & req_valid) !== 4'b0000 && !sb_drop) begin
          for (int l = 0; l < NREQ; l++) begin
            if (req_ready[l]) begin
              mon_m = fma_model(req_opa[32*l +: 32], req_opb[32*l +: 32],
                                req_opc[32*l +: 32], req_inv[l]);
              sb_q.push_back({req_ready, mon_m[31:0], mon_m[32], cyc + 32'(LAT + 2)});
            end
          end
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rand_ops;
    for (int l = 0; l < NREQ; l++) begin
      req_opa[32*l +: 32] = $urandom();
      req_opb[32*l +: 32] = $urandom();
      req_opc[32*l +: 32] = $urandom();
    end
    req_inv = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset;
    step();
    rst_n = 1'b0; req_valid = 4'b1111; cfg_wr = 1'b1; cfg_nj = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({fma_valid, res_valid, res_spec, err, cfg_busy, cfg_done, fma_nj, req_ready} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got fv=%b rv=%b rs=%b err=%b busy=%b done=%b nj=%b rdy=%b, expected all zero",
               fma_valid, res_valid, res_spec, err, cfg_busy, cfg_done, fma_nj, req_ready);
    end
    step();
    req_valid = 4'b0000; cfg_wr = 1'b0; cfg_nj = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    for (int i = 0; i < 12; i++) begin
      step();
      req_valid = 4'b1111;
      set_rand_ops();
      @(negedge clk);
      exp_g = 4'b0001 << (i % 4);
      checks++;
      if (req_ready !== exp_g) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b, expected %b", i, req_ready, exp_g);
      end
    end
    step();
    req_valid = 4'b0000;
    repeat (LAT + 4) step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: got %0d pending results, expected 0", sb_q.size());
    end
  endtask

  task automatic test_special;
    logic got;
    step();
    req_valid = 4'b0100; req_inv = 4'b0000;
    req_opa[64 +: 32] = 32'h7f80_0000; req_opb[64 +: 32] = 32'h0000_0000;
    req_opc[64 +: 32] = 32'h3f80_0000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL spec_grant: got %b, expected 0100", req_ready);
    end
    step();
    req_valid = 4'b0000;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      @(negedge clk);
      if (res_valid !== 4'b0000) begin
        got = 1'b1;
        checks++;
        if (res_valid !== 4'b0100 || res_data !== 32'h7fc0_0000 || res_spec !== 1'b1) begin
          errors++;
          $display("FAIL spec_result: got rv=%b data=%h spec=%b, expected rv=0100 data=7fc00000 spec=1",
                   res_valid, res_data, res_spec);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL spec_timeout: got no result, expected one within 20 cycles");
    end
  endtask

  task automatic test_flush;
    int cnt;
    for (int i = 0; i < 3; i++) begin
      step();
      req_valid = 4'b0111; sb_drop = 1'b1;
      set_rand_ops();
      @(negedge clk);
      checks++;
      if (req_ready !== (4'b0001 << i)) begin
        errors++;
        $display("FAIL flush_issue[%0d]: got %b, expected %b", i, req_ready, 4'b0001 << i);
      end
    end
    step();
    req_valid = 4'b0010; flush = 1'b1; sb_drop = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL flush_nogrant: got %b, expected 0000", req_ready);
    end
    step();
    flush = 1'b0;
    set_rand_ops();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL flush_next_grant: got %b, expected 0010", req_ready);
    end
    cnt = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      step();
      req_valid = 4'b0000;
      @(negedge clk);
      if (res_valid !== 4'b0000) cnt++;
    end
    checks++;
    if (cnt != 1 || err !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL flush_results: got count=%0d err=%b pending=%0d, expected count=1 err=0 pending=0",
               cnt, err, sb_q.size());
    end
  endtask

  task automatic test_cfg;
    logic done, bad;
    for (int i = 0; i < 2; i++) begin
      step();
      req_valid = 4'b0011;
      set_rand_ops();
      @(negedge clk);
      checks++;
      if (req_ready !== (4'b0001 << i)) begin
        errors++;
        $display("FAIL cfg_issue[%0d]: got %b, expected %b", i, req_ready, 4'b0001 << i);
      end
    end
    step();
    req_valid = 4'b1111; cfg_wr = 1'b1; cfg_nj = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL cfg_wr_nogrant: got %b, expected 0000", req_ready);
    end
    done = 1'b0; bad = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      cfg_wr = 1'b0; cfg_nj = 1'b0;
      @(negedge clk);
      if (cfg_done === 1'b1) done = 1'b1;
      else if (req_ready !== 4'b0000 || cfg_busy !== 1'b1 || fma_nj !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (!done || bad) begin
      errors++;
      $display("FAIL cfg_drain: got done=%b bad=%b, expected done=1 bad=0", done, bad);
    end
    checks++;
    if (fma_nj !== 1'b1 || cfg_busy !== 1'b1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL cfg_update: got nj=%b busy=%b pending=%0d, expected nj=1 busy=1 pending=0",
               fma_nj, cfg_busy, sb_q.size());
    end
    step();
    @(negedge clk);
    checks++;
    if (cfg_done !== 1'b0 || cfg_busy !== 1'b0 || req_ready !== 4'b0100 || fma_nj !== 1'b1) begin
      errors++;
      $display("FAIL cfg_resume: got done=%b busy=%b rdy=%b nj=%b, expected done=0 busy=0 rdy=0100 nj=1",
               cfg_done, cfg_busy, req_ready, fma_nj);
    end
    step();
    req_valid = 4'b0000;
    repeat (LAT + 4) step();
  endtask

  task automatic test_err;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_before: got %b, expected 0", err);
    end
    step();
    inj = 1'b1;
    step();
    inj = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b, expected 1", err);
    end
    repeat (5) step();
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, expected 1", err);
    end
  endtask

  task automatic test_reset_drain;
    step();
    req_valid = 4'b1000;
    set_rand_ops();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rd_issue: got %b, expected 1000", req_ready);
    end
    step();
    req_valid = 4'b0000; cfg_wr = 1'b1; cfg_nj = 1'b1;
    step();
    cfg_wr = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_busy: got %b, expected 1", cfg_busy);
    end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    checks++;
    if ({cfg_busy, fma_nj, err, fma_valid, res_valid, cfg_done} !== 9'd0) begin
      errors++;
      $display("FAIL rd_reset: got busy=%b nj=%b err=%b fv=%b rv=%b done=%b, expected all zero",
               cfg_busy, fma_nj, err, fma_valid, res_valid, cfg_done);
    end
    step();
    req_valid = 4'b1111;
    set_rand_ops();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rd_ptr: got %b, expected 0001", req_ready);
    end
    step();
    req_valid = 4'b0000;
    repeat (LAT + 8) step();
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL rd_final: got err=%b pending=%0d, expected err=0 pending=0", err, sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; req_valid = 4'b0000; req_inv = 4'b0000;
    req_opa = '0; req_opb = '0; req_opc = '0;
    flush = 1'b0; cfg_wr = 1'b0; cfg_nj = 1'b0; inj = 1'b0; sb_drop = 1'b0;
    test_reset();
    test_round_robin();
    test_special();
    test_flush();
    test_cfg();
    test_err();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
